intr_ack_ctrl: RTL

Interrupt request/acknowledge controller for the basic CPU. It latches rising edges on 8 interrupt lines into a pending register and gates them with a mask. It presents the masked pending set to the vector priority encoder as `intr_selec` and raises `intr_irq` to the CPU. When the CPU acknowledges with the 10-bit vector it branched to, the block decodes that vector back to a source index, retires the pending bit and holds the source in service until return-from-interrupt. Nesting is single-level.

---
 rtl/intr_ack_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/intr_ack_ctrl.sv
// Interrupt request/acknowledge controller: edge-latches 8 request lines, masks them,
// requests the CPU, decodes the acknowledged vector and tracks one in-service source.
module intr_ack_ctrl #(
    parameter logic [5:0] VEC_HI = 6'b111111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] intr_req,
    input  logic       intr_mask_we,
    input  logic [7:0] intr_mask_in,
    output logic [7:0] intr_selec,
    output logic       intr_irq,
    input  logic       intr_ack,
    input  logic [9:0] intr_dir_in,
    input  logic       intr_reti,
    output logic       intr_busy,
    output logic [2:0] intr_src,
    output logic       intr_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_reqQ;
    logic [7:0] r_pend;
    logic [7:0] r_mask;
    logic [2:0] r_src;
    logic       r_err;

    logic [7:0] w_edge;
    logic [7:0] w_active;
    logic [2:0] w_idx;
    logic       w_ackValid;
    logic       w_ackTaken;
    logic       w_errNext;
    logic [7:0] w_clearMask;

    assign w_edge     = intr_req & ~r_reqQ;
    assign w_active   = r_pend & r_mask;
    assign w_idx      = intr_dir_in[3:1];
    assign w_ackValid = (intr_dir_in[9:4] == VEC_HI) && !intr_dir_in[0]
                        && r_pend[w_idx] && r_mask[w_idx];
    assign w_ackTaken = intr_ack && (r_state == REQ) && w_ackValid;
    // An ack is only legal in REQ with a good vector; reti only in SERV.
    assign w_errNext  = (intr_ack && ((r_state != REQ) || !w_ackValid))
                        || (intr_reti && (r_state != SERV));

    always_comb begin
        w_clearMask = 8'h00;
        if (w_ackTaken) begin
            w_clearMask[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // req_q tracks the lines even in reset so a level held through reset is not an edge;
    // a same-cycle edge overrides the ack's clear so no request is lost.
    always_ff @(posedge clk) begin
        r_reqQ <= intr_req;
        if (reset) begin
            r_pend <= 8'h00;
            r_mask <= 8'h00;
            r_src  <= 3'd0;
            r_err  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clearMask) | w_edge;
            if (intr_mask_we) begin
                r_mask <= intr_mask_in;
            end
            if (w_ackTaken) begin
                r_src <= w_idx;
            end
            r_err <= w_errNext;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (|w_active) w_nextState = REQ;
            REQ: begin
                if (w_ackTaken) begin
                    w_nextState = SERV;
                end else if (!(|w_active)) begin
                    w_nextState = IDLE;
                end
            end
            SERV: if (intr_reti) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        intr_irq   = (r_state == REQ);
        intr_busy  = (r_state == SERV);
        intr_selec = (r_state != SERV) ? w_active : 8'h00;
    end

    assign intr_src = r_src;
    assign intr_err = r_err;

endmodule
